// File: rtl/data_mem_unit_if.sv
// Host preload/dump port of data_mem_unit: valid/ready request plus a one-cycle read-return pulse.
interface data_mem_unit_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata
    );
endinterface

// File: rtl/data_mem_unit.sv
// 128x32 data memory for the single-cycle MIPS core with post-reset clear and a host port.
// Optional macro DMEM_ACCESS_CNT_EN adds saturating core read/write access counters.
module data_mem_unit #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              init_busy,
    data_mem_unit_if.slave    host
`ifdef DMEM_ACCESS_CNT_EN
   ,output logic [15:0]       core_rd_cnt,
    output logic [15:0]       core_wr_cnt
`endif
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              idle;
    logic              core_wr;
    logic              core_rd;
    logic              host_xfer;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idle      = (state_q == ST_IDLE);
    assign core_wr   = idle && !CEN && !WEN;
    assign core_rd   = idle && !CEN && !OEN && WEN;
    assign host_xfer = host.host_valid && host.host_ready;

    assign init_busy        = (state_q == ST_CLEAR);
    assign host.host_ready  = idle && CEN;
    assign host.host_rvalid = rvalid_q;
    assign host.host_rdata  = rdata_q;

    // Read is asynchronous, so a simultaneous write to A still shows the old word.
    assign ReadDataMem = (idle && !CEN && !OEN) ? mem[A] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        rvalid_d = host_xfer && !host.host_we;
        rdata_d  = rdata_q;
        if (host_xfer && !host.host_we) begin
            rdata_d = mem[host.host_addr];
        end
    end

    // Only one writer per cycle: clear, then core, then host (host_ready excludes core cycles).
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
        end else if (core_wr) begin
            mem_we    = 1'b1;
            mem_waddr = A;
            mem_wdata = Data2Mem;
        end else if (host_xfer && host.host_we) begin
            mem_we    = 1'b1;
            mem_waddr = host.host_addr;
            mem_wdata = host.host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (core_rd && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (core_wr && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign core_rd_cnt = rd_cnt_q;
    assign core_wr_cnt = wr_cnt_q;
`else
    logic unused_core_rd;
    assign unused_core_rd = core_rd;
`endif
endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit with a behavioural memory model and directed anchor checks.
module tb_data_mem_unit;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              CEN = 1'b1;
    logic              WEN = 1'b1;
    logic              OEN = 1'b1;
    logic [ADDR_W-1:0] A = '0;
    logic [DATA_W-1:0] Data2Mem = '0;
    logic [DATA_W-1:0] ReadDataMem;
    logic              init_busy;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0]       core_rd_cnt;
    logic [15:0]       core_wr_cnt;
`endif

    data_mem_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

    data_mem_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .init_busy   (init_busy),
        .host        (hif)
`ifdef DMEM_ACCESS_CNT_EN
       ,.core_rd_cnt (core_rd_cnt),
        .core_wr_cnt (core_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a reset marks the array as all-zero (the clear is unobservable until it ends)
    // and blocks access for DEPTH cycles.
    int          clear_left = DEPTH;
    logic [31:0] mmem [DEPTH];
    logic        exp_rvalid = 1'b0;
    logic [31:0] exp_rdata = '0;
    int          exp_rd = 0;
    int          exp_wr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_left <= DEPTH;
            for (int i = 0; i < DEPTH; i++) mmem[i] <= '0;
            exp_rvalid <= 1'b0;
            exp_rdata  <= '0;
            exp_rd     <= 0;
            exp_wr     <= 0;
        end else if (clear_left > 0) begin
            clear_left <= clear_left - 1;
            exp_rvalid <= 1'b0;
        end else begin
            exp_rvalid <= 1'b0;
            if (!CEN) begin
                if (!WEN) begin
                    mmem[A] <= Data2Mem;
                    exp_wr  <= (exp_wr >= 65535) ? 65535 : exp_wr + 1;
                end else if (!OEN) begin
                    exp_rd  <= (exp_rd >= 65535) ? 65535 : exp_rd + 1;
                end
            end else if (hif.host_valid) begin
                if (hif.host_we) begin
                    mmem[hif.host_addr] <= hif.host_wdata;
                end else begin
                    exp_rdata  <= mmem[hif.host_addr];
                    exp_rvalid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic busy;
        busy = (clear_left > 0);
        check("init_busy", {31'd0, init_busy}, {31'd0, busy});
        check("host_ready", {31'd0, hif.host_ready}, {31'd0, !busy && CEN});
        check("ReadDataMem", ReadDataMem, (!busy && !CEN && !OEN) ? mmem[A] : 32'd0);
        check("host_rvalid", {31'd0, hif.host_rvalid}, {31'd0, exp_rvalid});
        check("host_rdata", hif.host_rdata, exp_rdata);
`ifdef DMEM_ACCESS_CNT_EN
        check("core_rd_cnt", {16'd0, core_rd_cnt}, exp_rd);
        check("core_wr_cnt", {16'd0, core_wr_cnt}, exp_wr);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
        hif.host_valid = 1'b0;
        hif.host_we    = 1'b0;
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        hif.host_valid = 1'b1; hif.host_we = 1'b1;
        hif.host_addr = addr; hif.host_wdata = data;
        tick();
        hif.host_valid = 1'b0; hif.host_we = 1'b0;
    endtask

    task automatic host_read_check(input string name, input logic [ADDR_W-1:0] addr,
                                   input logic [31:0] exp);
        hif.host_valid = 1'b1; hif.host_we = 1'b0; hif.host_addr = addr;
        #1;
        check({name, "_ready"}, {31'd0, hif.host_ready}, 32'd1);
        @(posedge clk);
        #1;
        hif.host_valid = 1'b0;
        check({name, "_rvalid"}, {31'd0, hif.host_rvalid}, 32'd1);
        check({name, "_rdata"}, hif.host_rdata, exp);
        tick();
        check({name, "_rvalid_drop"}, {31'd0, hif.host_rvalid}, 32'd0);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (init_busy && n < 300);
        check(name, n, 128);
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            CEN = ($urandom_range(0, 2) == 0);
            WEN = ($urandom_range(0, 2) != 0);
            OEN = $urandom_range(0, 1);
            A   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            Data2Mem       = $urandom;
            hif.host_valid = $urandom_range(0, 1);
            hif.host_we    = $urandom_range(0, 1);
            hif.host_addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            hif.host_wdata = $urandom;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hif.host_valid = 1'b0; hif.host_we = 1'b0;
        hif.host_addr = '0; hif.host_wdata = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("reset_busy", {31'd0, init_busy}, 32'd1);
        check("reset_rvalid", {31'd0, hif.host_rvalid}, 32'd0);
        check("reset_rdata", hif.host_rdata, 32'd0);
        rst_n = 1'b1;
        count_busy("clear_len");

        host_read_check("rd0", 7'd0, 32'd0);
        host_read_check("rd64", 7'd64, 32'd0);
        host_read_check("rd127", 7'd127, 32'd0);

        host_write(7'd5, 32'hDEADBEEF);
        CEN = 1'b0; OEN = 1'b0; A = 7'd5;
        #1;
        check("core_rd5", ReadDataMem, 32'hDEADBEEF);
        tick();
        idle_inputs();

        CEN = 1'b0; WEN = 1'b0; A = 7'd9; Data2Mem = 32'h1234;
        hif.host_valid = 1'b1; hif.host_we = 1'b0; hif.host_addr = 7'd9;
        #1;
        check("core_prio_ready", {31'd0, hif.host_ready}, 32'd0);
        @(posedge clk);
        #1;
        CEN = 1'b1; WEN = 1'b1;
        host_read_check("rd9", 7'd9, 32'h1234);

        host_write(7'd3, 32'd7);
        CEN = 1'b0; OEN = 1'b0; WEN = 1'b0; A = 7'd3; Data2Mem = 32'd8;
        #1;
        check("rmw_old", ReadDataMem, 32'd7);
        @(posedge clk);
        #1;
        WEN = 1'b1;
        #1;
        check("rmw_new", ReadDataMem, 32'd8);
        tick();
        idle_inputs();

        random_phase(2000);

        host_write(7'd100, 32'hFF);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        count_busy("clear_rerun_len");
        host_read_check("rd100", 7'd100, 32'd0);

`ifdef DMEM_ACCESS_CNT_EN
        for (int i = 0; i < 3; i++) begin
            CEN = 1'b0; OEN = 1'b0; WEN = 1'b1; A = ADDR_W'(i);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            CEN = 1'b0; WEN = 1'b0; A = ADDR_W'(20 + i); Data2Mem = 32'(i);
            tick();
        end
        idle_inputs();
        check("rd_cnt3", {16'd0, core_rd_cnt}, 32'd3);
        check("wr_cnt2", {16'd0, core_wr_cnt}, 32'd2);
        CEN = 1'b0; OEN = 1'b0; WEN = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        idle_inputs();
        check("rd_cnt_sat", {16'd0, core_rd_cnt}, 32'h0000FFFF);
`endif

        random_phase(1500);
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
